// File: rtl/uart_tx_configurable.sv
// UART serialiser with runtime parity (none/even/odd), 1/1.5/2 stop bits,
// a ready/start handshake and break generation, paced by the baud sample_tick.
module uart_tx_configurable #(
  parameter int DBITS      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] data_in,
  input  logic [1:0]       parity_mode,
  input  logic [1:0]       stop_sel,
  input  logic             tx_break,
  output logic             tx_ready,
  output logic             tx_done,
  output logic             tx
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(DBITS);

  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP1_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    tick_cnt, tick_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [DBITS-1:0] shift_reg, shift_n;
  logic             parity_en, parity_en_n;
  logic             parity_bit, parity_bit_n;
  logic [1:0]       stop_cfg, stop_cfg_n;
  logic             tx_n, tx_ready_n, tx_done_n;
  logic [TW-1:0]    stop_last;
  logic [TW-1:0]    tick_inc;
  logic             bit_end, stop_end;

  // Stop length comes from the configuration latched at acceptance.
  always_comb begin
    case (stop_cfg)
      2'b00:   stop_last = STOP1_LAST;
      2'b01:   stop_last = STOP15_LAST;
      default: stop_last = STOP2_LAST;
    endcase
  end

  assign tick_inc = sample_tick ? tick_cnt + 1'b1 : tick_cnt;
  assign bit_end  = sample_tick && (tick_cnt == BIT_LAST);
  assign stop_end = sample_tick && (tick_cnt == stop_last);

  always_comb begin
    state_n      = state;
    tick_n       = tick_cnt;
    bit_n        = bit_cnt;
    shift_n      = shift_reg;
    parity_en_n  = parity_en;
    parity_bit_n = parity_bit;
    stop_cfg_n   = stop_cfg;
    tx_done_n    = 1'b0;

    case (state)
      S_IDLE: begin
        // Break has priority over a simultaneous start request.
        if (tx_break) begin
          state_n = S_BREAK;
        end else if (tx_start && tx_ready) begin
          state_n      = S_START;
          tick_n       = '0;
          bit_n        = '0;
          shift_n      = data_in;
          parity_en_n  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          parity_bit_n = (^data_in) ^ parity_mode[1];
          stop_cfg_n   = stop_sel;
        end
      end

      S_START: begin
        tick_n = tick_inc;
        if (bit_end) begin
          state_n = S_DATA;
          tick_n  = '0;
        end
      end

      S_DATA: begin
        tick_n = tick_inc;
        if (bit_end) begin
          tick_n  = '0;
          shift_n = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = parity_en ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end

      S_PARITY: begin
        tick_n = tick_inc;
        if (bit_end) begin
          state_n = S_STOP;
          tick_n  = '0;
        end
      end

      S_STOP: begin
        tick_n = tick_inc;
        if (stop_end) begin
          state_n   = S_IDLE;
          tick_n    = '0;
          tx_done_n = 1'b1;
        end
      end

      S_BREAK: begin
        if (!tx_break) begin
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Line level is derived from the next state so it updates with the state.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = parity_bit_n;
      S_BREAK:  tx_n = 1'b0;
      default:  tx_n = 1'b1;
    endcase

    tx_ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_en  <= 1'b0;
      parity_bit <= 1'b0;
      stop_cfg   <= 2'b00;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shift_reg  <= shift_n;
      parity_en  <= parity_en_n;
      parity_bit <= parity_bit_n;
      stop_cfg   <= stop_cfg_n;
      tx         <= tx_n;
      tx_ready   <= tx_ready_n;
      tx_done    <= tx_done_n;
    end
  end

endmodule
